// File: rtl/serial_sub4_if.sv
// serial_sub4_if: start/operand/result bundle for the bit-serial subtractor.
// The ovf signal exists only when SERIAL_SUB4_OVF_EN is defined.
interface serial_sub4_if #(parameter int WIDTH = 4);
    logic             start;
    logic [WIDTH-1:0] a;
    logic [WIDTH-1:0] b;
    logic             b_in;
    logic [WIDTH-1:0] diff;
    logic             b_out;
    logic             busy;
    logic             done;
`ifdef SERIAL_SUB4_OVF_EN
    logic             ovf;
    modport master (output start, a, b, b_in, input diff, b_out, busy, done, ovf);
    modport slave  (input start, a, b, b_in, output diff, b_out, busy, done, ovf);
`else
    modport master (output start, a, b, b_in, input diff, b_out, busy, done);
    modport slave  (input start, a, b, b_in, output diff, b_out, busy, done);
`endif
endinterface

// File: rtl/serial_sub4.sv
// serial_sub4: bit-serial a - b - b_in, LSB first, one full-subtractor cell.
// Optional signed-overflow output enabled by defining SERIAL_SUB4_OVF_EN.
module serial_sub4 #(
    parameter int WIDTH = 4
) (
    input logic         clk,
    input logic         rst_n,
    serial_sub4_if.slave bus
);
    localparam int CW = $clog2(WIDTH) + 1;
    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    state_t           state, state_nx;
    logic [WIDTH-1:0] a_sr, b_sr, diff_r;
    logic [CW-1:0]    cnt;
    logic             br, b_out_r, accept, last, d, br_nx;
`ifdef SERIAL_SUB4_OVF_EN
    logic             a_msb, b_msb, ovf_r;
`endif
    always_comb begin
        accept   = bus.start && state != SHIFT;
        last     = cnt == CW'(WIDTH - 1);
        d        = a_sr[0] ^ b_sr[0] ^ br;
        br_nx    = (~a_sr[0] & b_sr[0]) | (~(a_sr[0] ^ b_sr[0]) & br);
        state_nx = accept ? SHIFT : (state == SHIFT ? (last ? DONE : SHIFT) : IDLE);
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) state <= IDLE;
        else        state <= state_nx;
    end
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            a_sr    <= '0;
            b_sr    <= '0;
            diff_r  <= '0;
            cnt     <= '0;
            br      <= 1'b0;
            b_out_r <= 1'b0;
`ifdef SERIAL_SUB4_OVF_EN
            a_msb   <= 1'b0;
            b_msb   <= 1'b0;
            ovf_r   <= 1'b0;
`endif
        end else if (accept) begin
            a_sr  <= bus.a;
            b_sr  <= bus.b;
            br    <= bus.b_in;
            cnt   <= '0;
`ifdef SERIAL_SUB4_OVF_EN
            a_msb <= bus.a[WIDTH-1];
            b_msb <= bus.b[WIDTH-1];
`endif
        end else if (state == SHIFT) begin
            a_sr   <= a_sr >> 1;
            b_sr   <= b_sr >> 1;
            br     <= br_nx;
            cnt    <= cnt + CW'(1);
            diff_r <= {d, diff_r[WIDTH-1:1]};
            if (last) begin
                b_out_r <= br_nx;
`ifdef SERIAL_SUB4_OVF_EN
                // d on the last bit is the final diff MSB
                ovf_r   <= (a_msb ^ b_msb) & (a_msb ^ d);
`endif
            end
        end
    end
    assign bus.diff  = diff_r;
    assign bus.b_out = b_out_r;
    assign bus.busy  = state == SHIFT;
    assign bus.done  = state == DONE;
`ifdef SERIAL_SUB4_OVF_EN
    assign bus.ovf   = ovf_r;
`endif
endmodule

// File: tb/tb_serial_sub4.sv
// tb_serial_sub4: directed checks of serial_sub4 with WIDTH=4.
module tb_serial_sub4;
    logic clk = 1'b0;
    logic rst_n;
    int   total = 0;
    int   bad = 0;
    int   n;
    logic seen;
    serial_sub4_if #(.WIDTH(4)) bus ();
    serial_sub4 #(.WIDTH(4)) dut (.clk(clk), .rst_n(rst_n), .bus(bus.slave));
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    task automatic wait_done(output int cnt);
        cnt = 0;
        do begin
            @(negedge clk);
            cnt++;
            if (cnt == 1) bus.start = 1'b0;
        end while (bus.done !== 1'b1 && cnt < 20);
    endtask

    task automatic run(input string tag, input logic [3:0] ra, input logic [3:0] rb,
                       input logic rbin, input logic [3:0] ed, input logic eb);
        int lat;
        @(negedge clk);
        bus.start = 1'b1;
        bus.a     = ra;
        bus.b     = rb;
        bus.b_in  = rbin;
        wait_done(lat);
        chk({tag, "_lat"}, lat, 5);
        chk({tag, "_diff"}, bus.diff, ed);
        chk({tag, "_bout"}, bus.b_out, eb);
        chk({tag, "_busy"}, bus.busy, 0);
    endtask

    initial begin
        rst_n = 1'b0;
        bus.start = 1'b0;
        bus.a = '0;
        bus.b = '0;
        bus.b_in = 1'b0;
        repeat (2) @(negedge clk);
        chk("rst_diff", bus.diff, 0);
        chk("rst_bout", bus.b_out, 0);
        chk("rst_busy", bus.busy, 0);
        chk("rst_done", bus.done, 0);
        rst_n = 1'b1;

        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd5; bus.b_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        for (int i = 0; i < 4; i++) begin
            chk("basic_busy", bus.busy, 1);
            chk("basic_nodone", bus.done, 0);
            @(negedge clk);
        end
        chk("basic_done", bus.done, 1);
        chk("basic_busy_low", bus.busy, 0);
        chk("basic_diff", bus.diff, 4);
        chk("basic_bout", bus.b_out, 0);
        @(negedge clk);
        chk("basic_pulse", bus.done, 0);
        chk("basic_hold", bus.diff, 4);

        run("wrap", 4'd3, 4'd5, 1'b0, 4'd14, 1'b1);
        run("bin", 4'd0, 4'd0, 1'b1, 4'd15, 1'b1);

        // stray start during SHIFT must be ignored
        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd5; bus.b_in = 1'b0;
        @(negedge clk);
        bus.a = 4'd1; bus.b = 4'd1;
        @(negedge clk);
        bus.start = 1'b0;
        wait_done(n);
        chk("ign_lat", n + 2, 5);
        chk("ign_diff", bus.diff, 4);
        bus.start = 1'b1; bus.a = 4'd7; bus.b = 4'd2; bus.b_in = 1'b0;
        wait_done(n);
        chk("b2b_lat", n, 5);
        chk("b2b_diff", bus.diff, 5);
        chk("b2b_bout", bus.b_out, 0);

        @(negedge clk);
        bus.start = 1'b1; bus.a = 4'd9; bus.b = 4'd5; bus.b_in = 1'b0;
        @(negedge clk);
        bus.start = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        chk("mid_rst_diff", bus.diff, 0);
        chk("mid_rst_bout", bus.b_out, 0);
        chk("mid_rst_busy", bus.busy, 0);
        chk("mid_rst_done", bus.done, 0);
        @(negedge clk);
        rst_n = 1'b1;
        seen = 1'b0;
        repeat (8) begin
            @(negedge clk);
            seen = seen | bus.done;
        end
        chk("mid_rst_nodone", seen, 0);

`ifdef SERIAL_SUB4_OVF_EN
        run("ovf8m1", 4'd8, 4'd1, 1'b0, 4'd7, 1'b0);
        chk("ovf8m1_ovf", bus.ovf, 1);
        run("ovf7m1", 4'd7, 4'd1, 1'b0, 4'd6, 1'b0);
        chk("ovf7m1_ovf", bus.ovf, 0);
`endif

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                for (int k = 0; k < 2; k++) begin
                    int r;
                    int s;
                    r = i - j - k;
                    s = (i > 7 ? i - 16 : i) - (j > 7 ? j - 16 : j) - k;
                    run("sweep", 4'(i), 4'(j), 1'(k), r[3:0], r < 0);
`ifdef SERIAL_SUB4_OVF_EN
                    chk("sweep_ovf", bus.ovf, (s < -8 || s > 7) ? 1 : 0);
`else
                    if (s > 99) $display("note: s=%0d", s);
`endif
                end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule
